// File: rtl/generic_sync_fifo_env_pkg.sv
// Shared definitions for the synchronous FIFO environment.
// Holds the read-mode encodings and the default geometry/threshold values
// used as parameter defaults by generic_sync_fifo_env.
package generic_sync_fifo_env_pkg;

    typedef enum int {
        FWFT_REGISTERED  = 0,   // rd_data registered, valid one cycle after pop
        FWFT_FALLTHROUGH = 1    // head word shown on rd_data whenever not empty
    } fwft_mode_e;

    localparam int DEF_DAT_WIDTH      = 20;
    localparam int DEF_NUM_OF_ENTRIES = 16;
    localparam int DEF_PTR_WIDTH      = 4;
    localparam int DEF_AF_LEVEL       = 12;
    localparam int DEF_AE_LEVEL       = 2;

endpackage

// File: rtl/generic_2p_1clk_rf.sv
// Two-port register file, single clock.
// Ports: clk; we/waddr/wdata  synchronous write port;
//        raddr/rdata          combinational read port.
// Contents are deliberately not reset.
module generic_2p_1clk_rf #(
    parameter int MEM_SIZE = 16,
    parameter int AW       = 4,
    parameter int DW       = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/generic_sync_fifo_env.sv
// Synchronous FIFO with occupancy flags and rejected-op error pulses.
// Ports: clk, reset (sync, active high), clear (sync flush);
//        wr_op/wr_data write side; rd_op pop, rd_data/rd_valid read side;
//        full/empty/almost_full/almost_empty decoded from entry_used;
//        wr_full_err/rd_empty_err one-cycle pulses after a rejected op.
// FWFT selects registered read (0) or first-word-fall-through (1).
module generic_sync_fifo_env
    import generic_sync_fifo_env_pkg::*;
#(
    parameter int DAT_WIDTH      = DEF_DAT_WIDTH,
    parameter int NUM_OF_ENTRIES = DEF_NUM_OF_ENTRIES,
    parameter int PTR_WIDTH      = DEF_PTR_WIDTH,
    parameter int AF_LEVEL       = DEF_AF_LEVEL,
    parameter int AE_LEVEL       = DEF_AE_LEVEL,
    parameter int FWFT           = FWFT_REGISTERED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_op,
    input  logic [DAT_WIDTH-1:0] wr_data,
    input  logic                 rd_op,
    output logic [DAT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   entry_used,
    output logic                 wr_full_err,
    output logic                 rd_empty_err
);

    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
    localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
    localparam logic [PTR_WIDTH:0]   CNT_AF   = (PTR_WIDTH+1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0]   CNT_AE   = (PTR_WIDTH+1)'(AE_LEVEL);

    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DAT_WIDTH-1:0] head;
    logic                 rd_acc, wr_acc, mem_we;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A pop frees a slot in the same edge, so a full FIFO still takes a write
    // when a read is accepted alongside it.
    assign rd_acc = rd_op && !empty;
    assign wr_acc = wr_op && (!full || rd_acc);
    assign mem_we = wr_acc && !clear && !reset;

    assign full         = (entry_used == CNT_FULL);
    assign empty        = (entry_used == '0);
    assign almost_full  = (entry_used >= CNT_AF);
    assign almost_empty = (entry_used <= CNT_AE);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            entry_used   <= '0;
            wr_full_err  <= 1'b0;
            rd_empty_err <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            entry_used   <= '0;
            wr_full_err  <= 1'b0;
            rd_empty_err <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   entry_used <= entry_used + 1'b1;
                2'b01:   entry_used <= entry_used - 1'b1;
                default: ;
            endcase
            wr_full_err  <= wr_op && !wr_acc;
            rd_empty_err <= rd_op && !rd_acc;
        end
    end

    generic_2p_1clk_rf #(
        .MEM_SIZE(NUM_OF_ENTRIES),
        .AW      (PTR_WIDTH),
        .DW      (DAT_WIDTH)
    ) u_rf (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(head)
    );

    generate
        if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
            // Storage is never reset, so mask stale words while empty.
            assign rd_data  = empty ? '0 : head;
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [DAT_WIDTH-1:0] rd_data_q;
            logic                 rd_valid_q;

            // rd_data_q survives clear: only the valid strobe is dropped.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (clear) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= head;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_generic_sync_fifo_env.sv
// Self-checking bench: three FIFO variants (defaults, 10-entry, FWFT=1)
// share one stimulus stream; a queue-based model predicts every output.
module tb_generic_sync_fifo_env;
    import generic_sync_fifo_env_pkg::*;

    localparam int NI = 3;
    localparam int DW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clear, wr_op, rd_op;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rd_data  [NI];
    logic          rd_valid [NI];
    logic          full     [NI];
    logic          empty    [NI];
    logic          af       [NI];
    logic          ae       [NI];
    logic          werr     [NI];
    logic          rerr     [NI];
    logic [4:0]    used     [NI];

    generic_sync_fifo_env #(.NUM_OF_ENTRIES(16), .PTR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)) u_def (
        .clk(clk), .reset(reset), .clear(clear), .wr_op(wr_op), .wr_data(wr_data), .rd_op(rd_op),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .entry_used(used[0]),
        .wr_full_err(werr[0]), .rd_empty_err(rerr[0]));

    generic_sync_fifo_env #(.NUM_OF_ENTRIES(10), .PTR_WIDTH(4), .AF_LEVEL(8), .AE_LEVEL(2), .FWFT(0)) u_n10 (
        .clk(clk), .reset(reset), .clear(clear), .wr_op(wr_op), .wr_data(wr_data), .rd_op(rd_op),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .entry_used(used[1]),
        .wr_full_err(werr[1]), .rd_empty_err(rerr[1]));

    generic_sync_fifo_env #(.NUM_OF_ENTRIES(16), .PTR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .wr_op(wr_op), .wr_data(wr_data), .rd_op(rd_op),
        .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .full(full[2]), .empty(empty[2]),
        .almost_full(af[2]), .almost_empty(ae[2]), .entry_used(used[2]),
        .wr_full_err(werr[2]), .rd_empty_err(rerr[2]));

    // reference model: one queue per variant plus the registered read outputs
    int p_n  [NI] = '{16, 10, 16};
    int p_af [NI] = '{12, 8, 12};
    int p_ae [NI] = '{2, 2, 2};
    int p_fw [NI] = '{0, 0, 1};

    logic [DW-1:0] mq [NI][$];
    logic [DW-1:0] m_rd   [NI];
    bit            m_rv   [NI];
    bit            m_werr [NI];
    bit            m_rerr [NI];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                mq[i].delete();
                m_rd[i] = '0; m_rv[i] = 0; m_werr[i] = 0; m_rerr[i] = 0;
            end else if (clear) begin
                mq[i].delete();
                m_rv[i] = 0; m_werr[i] = 0; m_rerr[i] = 0;
            end else begin
                int  sz;
                bit  racc, wacc;
                logic [DW-1:0] h;
                sz   = mq[i].size();
                racc = rd_op && (sz > 0);
                wacc = wr_op && ((sz < p_n[i]) || racc);
                m_werr[i] = wr_op && !wacc;
                m_rerr[i] = rd_op && !racc;
                m_rv[i]   = 0;
                if (racc) begin
                    h = mq[i].pop_front();
                    if (p_fw[i] == 0) begin
                        m_rd[i] = h;
                        m_rv[i] = 1;
                    end
                end
                if (wacc) mq[i].push_back(wr_data);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int sz;
            sz = mq[i].size();
            chk("entry_used", i, 32'(used[i]), 32'(sz));
            chk("full", i, 32'(full[i]), 32'(sz == p_n[i]));
            chk("empty", i, 32'(empty[i]), 32'(sz == 0));
            chk("almost_full", i, 32'(af[i]), 32'(sz >= p_af[i]));
            chk("almost_empty", i, 32'(ae[i]), 32'(sz <= p_ae[i]));
            chk("wr_full_err", i, 32'(werr[i]), 32'(m_werr[i]));
            chk("rd_empty_err", i, 32'(rerr[i]), 32'(m_rerr[i]));
            if (p_fw[i] == 1) begin
                chk("rd_valid", i, 32'(rd_valid[i]), 32'(sz > 0));
                chk("rd_data", i, 32'(rd_data[i]), (sz > 0) ? 32'(mq[i][0]) : 32'd0);
            end else begin
                chk("rd_valid", i, 32'(rd_valid[i]), 32'(m_rv[i]));
                chk("rd_data", i, 32'(rd_data[i]), 32'(m_rd[i]));
            end
        end
    endtask

    // drive one cycle of stimulus, advance the model, compare after the edge
    task automatic cycle(input bit r, input bit c, input bit w, input logic [DW-1:0] wd, input bit rd);
        reset = r; clear = c; wr_op = w; wr_data = wd; rd_op = rd;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        bit            rst, clr, wr, rd;
        logic [DW-1:0] wd;
        int            e_used;
        bit            e_empty, e_full, e_werr, e_rerr, e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        reset = 1'b1; clear = 1'b0; wr_op = 1'b0; rd_op = 1'b0; wr_data = '0;

        // directed table against the default FWFT=0 instance
        tbl[0] = '{1, 0, 0, 0, 20'h00000, 0, 1, 0, 0, 0, 0, 20'h00000};
        tbl[1] = '{0, 0, 0, 1, 20'h00000, 0, 1, 0, 0, 1, 0, 20'h00000};
        tbl[2] = '{0, 0, 1, 1, 20'hABCDE, 1, 0, 0, 0, 1, 0, 20'h00000};
        tbl[3] = '{0, 0, 0, 0, 20'h00000, 1, 0, 0, 0, 0, 0, 20'h00000};
        tbl[4] = '{0, 0, 0, 1, 20'h00000, 0, 1, 0, 0, 0, 1, 20'hABCDE};
        tbl[5] = '{0, 0, 0, 0, 20'h00000, 0, 1, 0, 0, 0, 0, 20'hABCDE};
        tbl[6] = '{0, 0, 1, 0, 20'h11111, 1, 0, 0, 0, 0, 0, 20'hABCDE};
        tbl[7] = '{0, 1, 1, 0, 20'h22222, 0, 1, 0, 0, 0, 0, 20'hABCDE};
        tbl[8] = '{0, 0, 1, 0, 20'h33333, 1, 0, 0, 0, 0, 0, 20'hABCDE};
        tbl[9] = '{0, 0, 0, 1, 20'h00000, 0, 1, 0, 0, 0, 1, 20'h33333};
        for (int k = 0; k < 10; k++) begin
            cycle(tbl[k].rst, tbl[k].clr, tbl[k].wr, tbl[k].wd, tbl[k].rd);
            chk("tbl_used", k, 32'(used[0]), 32'(tbl[k].e_used));
            chk("tbl_empty", k, 32'(empty[0]), 32'(tbl[k].e_empty));
            chk("tbl_full", k, 32'(full[0]), 32'(tbl[k].e_full));
            chk("tbl_werr", k, 32'(werr[0]), 32'(tbl[k].e_werr));
            chk("tbl_rerr", k, 32'(rerr[0]), 32'(tbl[k].e_rerr));
            chk("tbl_rv", k, 32'(rd_valid[0]), 32'(tbl[k].e_rv));
            chk("tbl_rd", k, 32'(rd_data[0]), 32'(tbl[k].e_rd));
        end

        // fill 16, then drain 16 in order with one-cycle latency
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            cycle(0, 0, 1, DW'(k + 1), 0);
            chk("fill_af", k, 32'(af[0]), 32'((k + 1) >= 12));
            chk("fill_full", k, 32'(full[0]), 32'((k + 1) == 16));
        end
        for (int k = 0; k < 16; k++) begin
            cycle(0, 0, 0, 0, 1);
            chk("drain_data", k, 32'(rd_data[0]), 32'(k + 1));
            chk("drain_valid", k, 32'(rd_valid[0]), 32'd1);
        end
        chk("drain_empty", 0, 32'(empty[0]), 32'd1);

        // full FIFO: simultaneous op is accepted, lone write is rejected
        for (int k = 0; k < 16; k++) cycle(0, 0, 1, DW'(32'h100 + k), 0);
        cycle(0, 0, 1, 20'hAAAAA, 1);
        chk("full_wr_rd_used", 0, 32'(used[0]), 32'd16);
        chk("full_wr_rd_err", 0, 32'(werr[0]), 32'd0);
        cycle(0, 0, 1, 20'hBBBBB, 0);
        chk("full_wr_err", 0, 32'(werr[0]), 32'd1);
        chk("full_wr_used", 0, 32'(used[0]), 32'd16);
        cycle(0, 0, 0, 0, 0);
        chk("full_err_pulse", 0, 32'(werr[0]), 32'd0);

        // fall-through view on the FWFT instance
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 20'h12345, 0);
        chk("fwft_data", 2, 32'(rd_data[2]), 32'h12345);
        chk("fwft_valid", 2, 32'(rd_valid[2]), 32'd1);
        cycle(0, 0, 0, 0, 1);
        chk("fwft_empty", 2, 32'(empty[2]), 32'd1);
        chk("fwft_zero", 2, 32'(rd_data[2]), 32'd0);

        // clear, then reset, each with five entries present and a write pending
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, DW'(32'h200 + k), 0);
        cycle(0, 1, 1, 20'hFFFFF, 1);
        chk("clr_used", 0, 32'(used[0]), 32'd0);
        chk("clr_werr", 0, 32'(werr[0]), 32'd0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, DW'(32'h300 + k), 0);
        cycle(1, 0, 1, 20'hEEEEE, 0);
        chk("rst_used", 0, 32'(used[0]), 32'd0);
        cycle(0, 0, 1, 20'h5A5A5, 0);
        cycle(0, 0, 0, 0, 1);
        chk("rst_first_word", 0, 32'(rd_data[0]), 32'h5A5A5);

        // random traffic with alternating write-heavy / read-heavy phases
        for (int c = 0; c < 3000; c++) begin
            bit r, cl, w, rd;
            int wp;
            wp = ((c / 150) % 2 == 0) ? 75 : 30;
            r  = ($urandom_range(0, 499) == 0);
            cl = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < (100 - wp));
            cycle(r, cl, w, DW'($urandom), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/generic_sync_fifo_env.md
GENERIC_SYNC_FIFO_ENV -- requirements
Module: generic_sync_fifo_env

Interface
REQ-001 SHALL have parameters: DAT_WIDTH, default 20, data width; NUM_OF_ENTRIES, default 16, depth 2..2^PTR_WIDTH, non-power-of-2 allowed.
REQ-002 SHALL have parameters: PTR_WIDTH, default 4, address width; AF_LEVEL, default 12, almost-full threshold; AE_LEVEL, default 2, almost-empty threshold; FWFT, default 0, 0=registered read, 1=first-word-fall-through.
REQ-003 SHALL have one clock and a synchronous, active-high reset; clk and reset are the first two ports.
REQ-004 Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- clear  in  1  synchronous flush
- wr_op  in  1  write request
- wr_data  in  DAT_WIDTH  write data
- rd_op  in  1  read/pop request
- rd_data  out  DAT_WIDTH  read data
- rd_valid  out  1  rd_data holds a popped/head word
- full  out  1  entry_used==NUM_OF_ENTRIES
- empty  out  1  entry_used==0
- almost_full  out  1  entry_used>=AF_LEVEL
- almost_empty  out  1  entry_used<=AE_LEVEL
- entry_used  out  PTR_WIDTH+1  occupancy 0..NUM_OF_ENTRIES
- wr_full_err  out  1  rejected-write pulse
- rd_empty_err  out  1  rejected-read pulse

Function
REQ-005 Write accepted iff wr_op && (!full || rd_acc); data stored at wr_ptr on that edge.
REQ-006 Read accepted (rd_acc) iff rd_op && !empty.
REQ-007 Write-while-full with accepted read SHALL succeed; write-while-empty with rd_op SHALL store the write and reject the read (rd_empty_err=1).
REQ-008 wr_ptr/rd_ptr advance by 1 per accepted op, wrapping NUM_OF_ENTRIES-1 -> 0.
REQ-009 entry_used: +1 write only, -1 read only, unchanged for both or neither; never exceeds NUM_OF_ENTRIES or underflows.
REQ-010 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered entry_used, valid in the cycle after the causing op.
REQ-011 FWFT=0: rd_data SHALL be registered head word, valid one cycle after rd_acc, rd_valid=1 for that cycle only; rd_data holds otherwise.
REQ-012 FWFT=1: rd_data SHALL equal head word whenever !empty, 0 when empty; rd_valid = !empty; rd_acc pops, next head visible next cycle.
REQ-013 wr_full_err/rd_empty_err SHALL pulse high exactly one cycle, the cycle after the rejected op, registered.
REQ-014 clear SHALL zero pointers, entry_used, error pulses and rd_valid next edge; storage contents and FWFT=0 rd_data unchanged; wr_op/rd_op in the clear cycle ignored, no errors flagged.
REQ-015 reset has priority over clear; clear over wr_op/rd_op.

Reset
REQ-016 While reset=1 at an edge: pointers=0, entry_used=0, rd_data=0, rd_valid=0, errors=0; hence empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0).
REQ-017 Storage array SHALL not be reset; reset mid-operation discards all contents; first accepted write after reset lands at address 0.

Structure
REQ-018 A shared package SHALL hold FWFT mode encodings and default DAT_WIDTH/NUM_OF_ENTRIES/PTR_WIDTH/threshold constants.
REQ-019 Storage SHALL be sub-module generic_2p_1clk_rf (single clock, sync write, combinational read, parameters MEM_SIZE/AW/DW); control and flags in generic_sync_fifo_env.

Verification
REQ-020 Defaults, FWFT=0: 16 writes 0x00001..0x00010 -> full=1, almost_full=1 from entry_used=12; 16 reads -> rd_data 0x00001..0x00010 in order, 1-cycle latency, empty=1.
REQ-021 Full FIFO, wr_op+rd_op same cycle -> both accepted, entry_used stays 16, no wr_full_err; wr_op alone -> wr_full_err one-cycle pulse, entry_used 16.
REQ-022 Empty FIFO, rd_op alone -> rd_empty_err pulse, rd_valid=0; wr_op+rd_op with wr_data=0xABCDE -> entry_used=1, rd_empty_err pulse.
REQ-023 NUM_OF_ENTRIES=10, PTR_WIDTH=4: 25 interleaved write/read pairs -> pointers wrap 9->0, data order preserved, full at entry_used=10.
REQ-024 FWFT=1: write 0x12345 -> next cycle rd_data=0x12345, rd_valid=1 without rd_op; rd_op -> empty=1, rd_data=0.
REQ-025 Five entries present, assert clear (then reset separately) with wr_op -> entry_used=0, empty=1, no errors; next write read back from address 0.
